argmax_stream: RTL and testbench
================================

// Module: argmax_stream
// PURPOSE
//  Classifier head that sits directly downstream of the final fully-connected layer (fc_<N>_<M>_<T>_<P>_<R>).
//  Consumes the layer's output stream of M signed T-bit values per input vector over a valid/ready handshake.
//  Emits, per vector, the index of the largest element together with its value, over a second valid/ready handshake.
//  Sustains one element per cycle, so it never throttles the fc layer unless its own output is back-pressured.
// PARAMETERS
//  M   2              elements per vector (M >= 1); equals the upstream fc layer's M
//  T   9              element width, two's complement signed
//  IW  max(1,$clog2(M)) width of output_idx; derived, not overridden
// PORTS
//  clk           in   1    clock; all state updates on the rising edge
//  reset         in   1    asynchronous, active-low reset (0 = in reset)
//  input_valid   in   1    input_data holds a valid element
//  input_ready   out  1    block accepts input_data this cycle
//  input_data    in   T    signed element; elements 0..M-1 of a vector arrive in order
//  output_valid  out  1    output_idx/output_max hold a completed result
//  output_ready  in   1    consumer takes the result this cycle
//  output_idx    out  IW   index (0..M-1) of the maximum element
//  output_max    out  T    signed value of the maximum element
// BEHAVIOUR
//  - Transfers: an element is accepted when input_valid && input_ready at a rising edge.
//    A result is taken when output_valid && output_ready at a rising edge.
//  - State held:
//    - cnt: 0..M-1, element position within the current vector.
//    - run_max, run_idx: running maximum and its index.
//    - A one-entry result register driving output_max, output_idx and output_valid.
//  - Accept at cnt==0: load run_max=input_data, run_idx=0, unconditionally.
//  - Accept at cnt=k>0: if signed(input_data) > run_max (strictly greater), load run_max=input_data, run_idx=k.
//    Otherwise hold. Ties therefore keep the lowest index.
//  - cnt increments on every accept and wraps to 0 after M-1.
//  - Accept at cnt==M-1: the final max/idx (including this element's comparison) goes to the result register.
//    output_valid=1 on the next cycle, so latency is 1 cycle from the last element to output_valid.
//  - M==1: every element completes a vector; output_idx is always 0.
//  - The result register holds stable while output_valid && !output_ready.
//    output_valid clears after a take unless a new result loads on the same edge.
//  - input_ready = !(cnt==M-1 && output_valid && !output_ready).
//    - Non-final elements are always accepted.
//    - The final element stalls only while the result slot is full and not draining.
//    - Simultaneous take and final-element accept is legal: the new result replaces the old one in the same cycle,
//      and output_valid stays 1.
//    - Combinational path output_ready -> input_ready is intended.
//  - No arithmetic beyond signed comparison; widths never grow.
//    -2^(T-1) and 2^(T-1)-1 must compare correctly.
//  - Reset (asserted, reset==0, at any time including mid-vector):
//    - cnt=0, run_max=0, run_idx=0, output_valid=0, output_idx=0, output_max=0.
//    - A partial vector is discarded.
//    - input_ready reads 1 from the first cycle after release.
//    - Nothing is accepted or emitted while reset==0.
// TESTING  (M=2, T=9 unless stated)
//  1. Vector (5,-3) -> one result: idx=0, max=5, one cycle after the second element is accepted.
//  2. Vector (-256,255) -> idx=1, max=255; then (-256,-255) -> idx=1, max=-255 (signed extremes).
//  3. Tie (7,7) -> idx=0, max=7; M=3 vector (4,9,9) -> idx=1, max=9.
//  4. output_ready=0 for 10 cycles while streaming (1,2),(3,0) -> input_ready=0 only on the 4th element until the first take.
//     Then results come out in order: (idx1,2), (idx0,3). No loss, no duplicate.
//  5. Accept element 8, assert reset for 2 cycles, then send (1,2) -> exactly one result: idx=1, max=2.
//     output_valid=0 throughout reset.
//  6. 10000 random vectors with 50% random input_valid/output_ready -> all results match the software argmax model, zero errors.

Source files
------------

// File: rtl/argmax_stream_if.sv
// Stream bundle between the fc layer, the argmax head and the result consumer.
// The slave modport is the argmax head's view; master is the surrounding producer/consumer.
interface argmax_stream_if #(
    parameter int M = 2,
    parameter int T = 9
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    logic          input_valid;
    logic          input_ready;
    logic [T-1:0]  input_data;
    logic          output_valid;
    logic          output_ready;
    logic [IW-1:0] output_idx;
    logic [T-1:0]  output_max;

    modport master (
        output input_valid, input_data, output_ready,
        input  input_ready, output_valid, output_idx, output_max
    );

    modport slave (
        input  input_valid, input_data, output_ready,
        output input_ready, output_valid, output_idx, output_max
    );
endinterface

// File: rtl/argmax_stream.sv
// Streaming argmax over M signed elements per vector, one element per cycle,
// with a single-entry result register that can be replaced on the same edge it drains.
module argmax_stream #(
    parameter int M = 2,
    parameter int T = 9
) (
    input logic           clk,
    input logic           reset,
    argmax_stream_if.slave bus
);
    localparam int            IW   = (M > 1) ? $clog2(M) : 1;
    localparam logic [IW-1:0] LAST = IW'(M - 1);

    logic [IW-1:0]       cnt;
    logic signed [T-1:0] run_max;
    logic [IW-1:0]       run_idx;
    logic signed [T-1:0] in_val;
    logic signed [T-1:0] cand_max;
    logic [IW-1:0]       cand_idx;
    logic                res_valid;
    logic [IW-1:0]       res_idx;
    logic [T-1:0]        res_max;
    logic                at_last;
    logic                accept;
    logic                take;

    assign in_val  = $signed(bus.input_data);
    assign at_last = (cnt == LAST);
    assign take    = res_valid && bus.output_ready;

    // Only the final element needs the result slot, so only it can stall.
    assign bus.input_ready = !(at_last && res_valid && !bus.output_ready);
    assign accept          = bus.input_valid && bus.input_ready;

    // Running max including the element currently on the bus; strict compare keeps the lowest index on ties.
    always_comb begin
        cand_max = run_max;
        cand_idx = run_idx;
        if (cnt == '0) begin
            cand_max = in_val;
            cand_idx = '0;
        end else if (in_val > run_max) begin
            cand_max = in_val;
            cand_idx = cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            run_max <= '0;
            run_idx <= '0;
        end else if (accept) begin
            cnt     <= at_last ? '0 : cnt + IW'(1);
            run_max <= cand_max;
            run_idx <= cand_idx;
        end
    end

    // A completing vector overwrites the slot even while it is being taken, keeping output_valid high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_max   <= '0;
        end else if (accept && at_last) begin
            res_valid <= 1'b1;
            res_idx   <= cand_idx;
            res_max   <= cand_max;
        end else if (take) begin
            res_valid <= 1'b0;
        end
    end

    assign bus.output_valid = res_valid;
    assign bus.output_idx   = res_idx;
    assign bus.output_max   = res_max;
endmodule

// File: tb/tb_argmax_stream.sv
// Scoreboard bench for argmax_stream: an M=2 and an M=3 instance checked against a
// queue-based software argmax model, with directed corner cases and a randomized run.
module tb_argmax_stream;
    localparam int T = 9;

    typedef struct {
        int idx;
        int mx;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    argmax_stream_if #(.M(2), .T(T)) bus2 ();
    argmax_stream_if #(.M(3), .T(T)) bus3 ();

    argmax_stream #(.M(2), .T(T)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    argmax_stream #(.M(3), .T(T)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    res_t exp2[$];
    res_t exp3[$];
    int   vec2[$];
    int   vec3[$];
    int   checks = 0;
    int   errors = 0;
    int   done2  = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic res_t refArgmax(input int v[$]);
        res_t r;
        r.idx = 0;
        for (int i = 1; i < v.size(); i++)
            if (v[i] > v[r.idx]) r.idx = i;
        r.mx = v[r.idx];
        return r;
    endfunction

    function automatic int randVal();
        case ($urandom_range(0, 3))
            0:       return -256;
            1:       return 255;
            2:       return int'($urandom_range(0, 6)) - 3;
            default: return int'($urandom_range(0, 511)) - 256;
        endcase
    endfunction

    task automatic modelAccept2(input int d);
        vec2.push_back(d);
        if (vec2.size() == 2) begin
            exp2.push_back(refArgmax(vec2));
            vec2.delete();
            done2++;
        end
    endtask

    task automatic modelAccept3(input int d);
        vec3.push_back(d);
        if (vec3.size() == 3) begin
            exp3.push_back(refArgmax(vec3));
            vec3.delete();
        end
    endtask

    // Drive one cycle on both instances; handshakes are resolved just after the falling edge.
    task automatic applyStimulus(input bit v2, input int d2, input bit r2,
                                 input bit v3, input int d3, input bit r3,
                                 output bit f2, output bit f3);
        @(negedge clk);
        bus2.input_valid  = v2;
        bus2.input_data   = T'(d2);
        bus2.output_ready = r2;
        bus3.input_valid  = v3;
        bus3.input_data   = T'(d3);
        bus3.output_ready = r3;
        #1;
        f2 = v2 && bus2.input_ready;
        f3 = v3 && bus3.input_ready;
        if (f2) modelAccept2(d2);
        if (f3) modelAccept3(d3);
    endtask

    task automatic idle(input int n);
        bit f2, f3;
        repeat (n) applyStimulus(0, 0, 1, 0, 0, 1, f2, f3);
    endtask

    task automatic send2(input int d, input bit r);
        bit f2, f3;
        int n = 0;
        do begin
            applyStimulus(1, d, r, 0, 0, 1, f2, f3);
            n++;
        end while (!f2 && n < 20);
        if (!f2) checkOutput("d2_send_timeout", 0, 1);
    endtask

    task automatic send3(input int d);
        bit f2, f3;
        int n = 0;
        do begin
            applyStimulus(0, 0, 1, 1, d, 1, f2, f3);
            n++;
        end while (!f3 && n < 20);
        if (!f3) checkOutput("d3_send_timeout", 0, 1);
    endtask

    // Results still in flight are legitimately lost when reset hits.
    task automatic doReset(input int n);
        @(negedge clk);
        reset = 1'b0;
        bus2.input_valid = 1'b0;
        bus3.input_valid = 1'b0;
        vec2.delete();
        vec3.delete();
        exp2.delete();
        exp3.delete();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checkOutput("rst_d2_valid", int'(bus2.output_valid), 0);
            checkOutput("rst_d3_valid", int'(bus3.output_valid), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rel_d2_ready", int'(bus2.input_ready), 1);
        checkOutput("rel_d2_valid", int'(bus2.output_valid), 0);
        checkOutput("rel_d2_idx", int'(bus2.output_idx), 0);
        checkOutput("rel_d2_max", int'(bus2.output_max), 0);
        checkOutput("rel_d3_ready", int'(bus3.input_ready), 1);
    endtask

    always begin
        res_t e;
        @(negedge clk);
        #2;
        if (reset && bus2.output_valid && bus2.output_ready) begin
            if (exp2.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL d2_unexpected: got idx=%0d max=%0d, expected no result",
                         bus2.output_idx, $signed(bus2.output_max));
            end else begin
                e = exp2.pop_front();
                checkOutput("d2_idx", int'(bus2.output_idx), e.idx);
                checkOutput("d2_max", int'($signed(bus2.output_max)), e.mx);
            end
        end
    end

    always begin
        res_t e;
        @(negedge clk);
        #2;
        if (reset && bus3.output_valid && bus3.output_ready) begin
            if (exp3.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL d3_unexpected: got idx=%0d max=%0d, expected no result",
                         bus3.output_idx, $signed(bus3.output_max));
            end else begin
                e = exp3.pop_front();
                checkOutput("d3_idx", int'(bus3.output_idx), e.idx);
                checkOutput("d3_max", int'($signed(bus3.output_max)), e.mx);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit   f2, f3;
        int   t4[4] = '{1, 2, 3, 0};
        int   e;
        int   cyc;
        int   start;

        bus2.input_valid  = 1'b0;
        bus2.input_data   = '0;
        bus2.output_ready = 1'b0;
        bus3.input_valid  = 1'b0;
        bus3.input_data   = '0;
        bus3.output_ready = 1'b0;

        doReset(3);

        // Basic vector and one-cycle result latency.
        send2(5, 1);
        send2(-3, 1);
        checkOutput("t1_valid_before", int'(bus2.output_valid), 0);
        idle(1);
        checkOutput("t1_latency", int'(bus2.output_valid), 1);
        idle(1);
        checkOutput("t1_cleared", int'(bus2.output_valid), 0);

        // Signed extremes, ties, and the M=3 instance.
        send2(-256, 1);
        send2(255, 1);
        send2(-256, 1);
        send2(-255, 1);
        send2(7, 1);
        send2(7, 1);
        send3(4);
        send3(9);
        send3(9);
        idle(3);

        // Back-pressure: the fourth element must stall until the first result is taken.
        e = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1, t4[e], 0, 0, 0, 1, f2, f3);
            if (e < 3) checkOutput("t4_accept", int'(f2), 1);
            else       checkOutput("t4_stall", int'(f2), 0);
            if (f2 && e < 3) e++;
        end
        applyStimulus(1, t4[3], 1, 0, 0, 1, f2, f3);
        checkOutput("t4_release", int'(f2), 1);
        idle(3);

        // Partial vector discarded by a mid-vector reset.
        send2(8, 1);
        checkOutput("pre_reset_drained", exp2.size(), 0);
        doReset(2);
        send2(1, 1);
        send2(2, 1);
        idle(3);
        checkOutput("t5_one_result", exp2.size(), 0);

        // Randomized traffic on both instances with random valid and back-pressure.
        start = done2;
        cyc   = 0;
        while (done2 - start < 10000 && cyc < 80000) begin
            applyStimulus(1'($urandom_range(0, 1)), randVal(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), randVal(), 1'($urandom_range(0, 1)),
                          f2, f3);
            cyc++;
        end
        checkOutput("random_vectors_done", (done2 - start >= 10000) ? 1 : 0, 1);
        idle(5);
        checkOutput("d2_drained", exp2.size(), 0);
        checkOutput("d3_drained", exp3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
